axi4_sram_slave: RTL and testbench

- AXI4 slave memory that sits directly downstream of the SoC top's 64-bit AXI4 master port.
- Absorbs the Tile's instruction/data refill and writeback bursts into an on-chip word array.
- Used as the simulation/bring-up memory behind the master interface; independent read and write channel FSMs.
- Supports FIXED and INCR bursts up to 256 beats, byte strobes, and DECERR for addresses outside the window.

---
 rtl/axi4_sram_slave.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_axi4_sram_slave.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_sram_slave.sv
// AXI4 slave word-array memory with independent read and write burst FSMs.
// Optional macro AXI_SRAM_RDELAY_EN inserts RDELAY idle cycles before the first R beat.
module axi4_sram_slave #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 64,
  parameter int                ID_W       = 4,
  parameter int                DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                RDELAY     = 3
) (
  input  logic                clock,
  input  logic                reset,
  output logic                io_awready,
  input  logic                io_awvalid,
  input  logic [ADDR_W-1:0]   io_awaddr,
  input  logic [ID_W-1:0]     io_awid,
  input  logic [7:0]          io_awlen,
  input  logic [2:0]          io_awsize,
  input  logic [1:0]          io_awburst,
  output logic                io_wready,
  input  logic                io_wvalid,
  input  logic [DATA_W-1:0]   io_wdata,
  input  logic [DATA_W/8-1:0] io_wstrb,
  input  logic                io_wlast,
  input  logic                io_bready,
  output logic                io_bvalid,
  output logic [1:0]          io_bresp,
  output logic [ID_W-1:0]     io_bid,
  output logic                io_arready,
  input  logic                io_arvalid,
  input  logic [ADDR_W-1:0]   io_araddr,
  input  logic [ID_W-1:0]     io_arid,
  input  logic [7:0]          io_arlen,
  input  logic [2:0]          io_arsize,
  input  logic [1:0]          io_arburst,
  input  logic                io_rready,
  output logic                io_rvalid,
  output logic [1:0]          io_rresp,
  output logic [DATA_W-1:0]   io_rdata,
  output logic                io_rlast,
  output logic [ID_W-1:0]     io_rid
);

  localparam int STRB_W = DATA_W / 8;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(1) << (DEPTH_LOG2 + 3);
`ifdef AXI_SRAM_RDELAY_EN
  localparam bit RDELAY_ON = (RDELAY != 0);
`else
  localparam bit RDELAY_ON = 1'b0;
`endif

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  function automatic logic in_window(input logic [ADDR_W-1:0] addr);
    return (addr - BASE_ADDR) < WIN_BYTES;
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_index(input logic [ADDR_W-1:0] addr);
    return DEPTH_LOG2'((addr - BASE_ADDR) >> 3);
  endfunction

  // WRAP steps like INCR; reserved burst type holds the address like FIXED
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [2:0] size,
                                                  input logic [1:0] burst);
    case (burst)
      2'b01, 2'b10: next_addr = addr + (ADDR_W'(1) << size);
      default:      next_addr = addr;
    endcase
  endfunction

  logic [DATA_W-1:0]     mem_r [DEPTH];

  r_state_t              r_state_r;
  logic [ADDR_W-1:0]     r_addr_r;
  logic [7:0]            r_len_r;
  logic [2:0]            r_size_r;
  logic [1:0]            r_burst_r;
  logic [7:0]            r_beat_r;
  logic [7:0]            r_wait_r;

  w_state_t              w_state_r;
  logic [ADDR_W-1:0]     w_addr_r;
  logic [ID_W-1:0]       w_id_r;
  logic [7:0]            w_len_r;
  logic [2:0]            w_size_r;
  logic [1:0]            w_burst_r;
  logic [7:0]            w_beat_r;
  logic                  w_dec_r;

  logic                  w_fire_s;
  logic                  w_inwin_s;
  logic                  w_commit_s;
  logic [DEPTH_LOG2-1:0] w_idx_s;
  logic                  r_fire_s;
  logic [ADDR_W-1:0]     r_next_addr_s;
  logic [ADDR_W-1:0]     r_fetch_addr_s;
  logic [DEPTH_LOG2-1:0] r_fetch_idx_s;
  logic                  r_fetch_inwin_s;
  logic [DATA_W-1:0]     r_fetch_data_s;

  assign w_fire_s        = io_wvalid & io_wready;
  assign w_inwin_s       = in_window(w_addr_r);
  assign w_idx_s         = word_index(w_addr_r);
  assign w_commit_s      = w_fire_s & w_inwin_s;
  assign r_fire_s        = io_rvalid & io_rready;
  assign r_next_addr_s   = next_addr(r_addr_r, r_size_r, r_burst_r);
  assign r_fetch_idx_s   = word_index(r_fetch_addr_s);
  assign r_fetch_inwin_s = in_window(r_fetch_addr_s);

  // Address of the beat that will be presented after the coming edge
  always_comb begin
    r_fetch_addr_s = r_addr_r;
    case (r_state_r)
      R_IDLE:  r_fetch_addr_s = io_araddr;
      R_DATA:  r_fetch_addr_s = r_next_addr_s;
      default: r_fetch_addr_s = r_addr_r;
    endcase
  end

  // Beat data with same-edge write bypass so a committed write is seen from the next cycle
  always_comb begin
    r_fetch_data_s = {DATA_W{1'b0}};
    for (int b = 0; b < STRB_W; b++) begin
      if (!r_fetch_inwin_s) begin
        r_fetch_data_s[8*b +: 8] = 8'h00;
      end else if (w_commit_s && (w_idx_s == r_fetch_idx_s) && io_wstrb[b]) begin
        r_fetch_data_s[8*b +: 8] = io_wdata[8*b +: 8];
      end else begin
        r_fetch_data_s[8*b +: 8] = mem_r[r_fetch_idx_s][8*b +: 8];
      end
    end
  end

  // Byte-strobed array write; contents survive reset
  always_ff @(posedge clock) begin
    if (w_commit_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (io_wstrb[b]) mem_r[w_idx_s][8*b +: 8] <= io_wdata[8*b +: 8];
      end
    end
  end

  // Read channel FSM; R outputs only change on a beat handshake
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state_r  <= R_IDLE;
      r_addr_r   <= {ADDR_W{1'b0}};
      r_len_r    <= 8'd0;
      r_size_r   <= 3'd0;
      r_burst_r  <= 2'b00;
      r_beat_r   <= 8'd0;
      r_wait_r   <= 8'd0;
      io_arready <= 1'b0;
      io_rvalid  <= 1'b0;
      io_rresp   <= 2'b00;
      io_rdata   <= {DATA_W{1'b0}};
      io_rlast   <= 1'b0;
      io_rid     <= {ID_W{1'b0}};
    end else begin
      case (r_state_r)
        R_IDLE: begin
          io_arready <= 1'b1;
          if (io_arvalid && io_arready) begin
            io_arready <= 1'b0;
            r_addr_r   <= io_araddr;
            r_len_r    <= io_arlen;
            r_size_r   <= io_arsize;
            r_burst_r  <= io_arburst;
            r_beat_r   <= 8'd0;
            r_wait_r   <= 8'd0;
            io_rid     <= io_arid;
            if (RDELAY_ON) begin
              r_state_r <= R_WAIT;
            end else begin
              io_rvalid <= 1'b1;
              io_rdata  <= r_fetch_data_s;
              io_rresp  <= r_fetch_inwin_s ? 2'b00 : 2'b11;
              io_rlast  <= (io_arlen == 8'd0);
              r_state_r <= R_DATA;
            end
          end
        end
        R_WAIT: begin
          if (r_wait_r == 8'(RDELAY - 1)) begin
            io_rvalid <= 1'b1;
            io_rdata  <= r_fetch_data_s;
            io_rresp  <= r_fetch_inwin_s ? 2'b00 : 2'b11;
            io_rlast  <= (r_len_r == 8'd0);
            r_state_r <= R_DATA;
          end else begin
            r_wait_r <= r_wait_r + 8'd1;
          end
        end
        R_DATA: begin
          if (r_fire_s) begin
            if (io_rlast) begin
              io_rvalid  <= 1'b0;
              io_rlast   <= 1'b0;
              io_rresp   <= 2'b00;
              io_rdata   <= {DATA_W{1'b0}};
              io_arready <= 1'b1;
              r_state_r  <= R_IDLE;
            end else begin
              r_addr_r <= r_next_addr_s;
              r_beat_r <= r_beat_r + 8'd1;
              io_rdata <= r_fetch_data_s;
              io_rresp <= r_fetch_inwin_s ? 2'b00 : 2'b11;
              io_rlast <= ((r_beat_r + 8'd1) == r_len_r);
            end
          end
        end
        default: begin
          io_rvalid <= 1'b0;
          io_rlast  <= 1'b0;
          r_state_r <= R_IDLE;
        end
      endcase
    end
  end

  // Write channel FSM; DECERR is sticky and outranks a short-burst SLVERR
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state_r  <= W_IDLE;
      w_addr_r   <= {ADDR_W{1'b0}};
      w_id_r     <= {ID_W{1'b0}};
      w_len_r    <= 8'd0;
      w_size_r   <= 3'd0;
      w_burst_r  <= 2'b00;
      w_beat_r   <= 8'd0;
      w_dec_r    <= 1'b0;
      io_awready <= 1'b0;
      io_wready  <= 1'b0;
      io_bvalid  <= 1'b0;
      io_bresp   <= 2'b00;
      io_bid     <= {ID_W{1'b0}};
    end else begin
      case (w_state_r)
        W_IDLE: begin
          io_awready <= 1'b1;
          if (io_awvalid && io_awready) begin
            io_awready <= 1'b0;
            io_wready  <= 1'b1;
            w_addr_r   <= io_awaddr;
            w_id_r     <= io_awid;
            w_len_r    <= io_awlen;
            w_size_r   <= io_awsize;
            w_burst_r  <= io_awburst;
            w_beat_r   <= 8'd0;
            w_dec_r    <= !in_window(io_awaddr);
            w_state_r  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire_s) begin
            w_addr_r <= next_addr(w_addr_r, w_size_r, w_burst_r);
            w_beat_r <= w_beat_r + 8'd1;
            if (!w_inwin_s) w_dec_r <= 1'b1;
            if (io_wlast) begin
              io_wready <= 1'b0;
              io_bvalid <= 1'b1;
              io_bid    <= w_id_r;
              io_bresp  <= (w_dec_r || !w_inwin_s) ? 2'b11 :
                           (w_beat_r != w_len_r)   ? 2'b10 : 2'b00;
              w_state_r <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (io_bready) begin
            io_bvalid  <= 1'b0;
            io_bresp   <= 2'b00;
            io_awready <= 1'b1;
            w_state_r  <= W_IDLE;
          end
        end
        default: begin
          io_wready <= 1'b0;
          io_bvalid <= 1'b0;
          w_state_r <= W_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Scoreboard bench for axi4_sram_slave: a byte-level memory model predicts every B and R beat,
// expectations are queued when a burst is issued and popped as the DUT responds.
module tb_axi4_sram_slave;

`ifdef AXI_SRAM_RDELAY_EN
  localparam int EXP_LAT = 4;
`else
  localparam int EXP_LAT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        io_awready, io_awvalid;
  logic [31:0] io_awaddr;
  logic [3:0]  io_awid;
  logic [7:0]  io_awlen;
  logic [2:0]  io_awsize;
  logic [1:0]  io_awburst;
  logic        io_wready, io_wvalid, io_wlast;
  logic [63:0] io_wdata;
  logic [7:0]  io_wstrb;
  logic        io_bready, io_bvalid;
  logic [1:0]  io_bresp;
  logic [3:0]  io_bid;
  logic        io_arready, io_arvalid;
  logic [31:0] io_araddr;
  logic [3:0]  io_arid;
  logic [7:0]  io_arlen;
  logic [2:0]  io_arsize;
  logic [1:0]  io_arburst;
  logic        io_rready, io_rvalid, io_rlast;
  logic [1:0]  io_rresp;
  logic [63:0] io_rdata;
  logic [3:0]  io_rid;

  axi4_sram_slave dut (
    .clock(clock), .reset(reset),
    .io_awready(io_awready), .io_awvalid(io_awvalid), .io_awaddr(io_awaddr), .io_awid(io_awid),
    .io_awlen(io_awlen), .io_awsize(io_awsize), .io_awburst(io_awburst),
    .io_wready(io_wready), .io_wvalid(io_wvalid), .io_wdata(io_wdata), .io_wstrb(io_wstrb),
    .io_wlast(io_wlast),
    .io_bready(io_bready), .io_bvalid(io_bvalid), .io_bresp(io_bresp), .io_bid(io_bid),
    .io_arready(io_arready), .io_arvalid(io_arvalid), .io_araddr(io_araddr), .io_arid(io_arid),
    .io_arlen(io_arlen), .io_arsize(io_arsize), .io_arburst(io_arburst),
    .io_rready(io_rready), .io_rvalid(io_rvalid), .io_rresp(io_rresp), .io_rdata(io_rdata),
    .io_rlast(io_rlast), .io_rid(io_rid)
  );

  always #5 clock = ~clock;

  typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic [3:0] id; } r_exp_t;
  typedef struct { logic [1:0] resp; logic [3:0] id; } b_exp_t;

  r_exp_t      r_q[$];
  b_exp_t      b_q[$];
  logic [63:0] model_mem [int];
  logic [63:0] wr_data [16];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_inwin(input logic [31:0] a);
    return (a >= 32'h8000_0000) && (a < 32'h8000_8000);
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - 32'h8000_0000) >> 3);
  endfunction

  function automatic logic [31:0] model_step(input logic [31:0] a, input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + 32'd8;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [1:0] burst, input int nbeats, input logic [7:0] strb);
    logic [31:0] a;
    logic [63:0] w;
    logic        dec;
    b_exp_t      be;
    int          t;
    a   = addr;
    dec = !model_inwin(addr);
    for (int i = 0; i < nbeats; i++) begin
      if (model_inwin(a)) begin
        w = model_mem.exists(model_idx(a)) ? model_mem[model_idx(a)] : 64'h0;
        for (int k = 0; k < 8; k++) if (strb[k]) w[8*k +: 8] = wr_data[i][8*k +: 8];
        model_mem[model_idx(a)] = w;
      end else begin
        dec = 1'b1;
      end
      a = model_step(a, burst);
    end
    be.id   = id;
    be.resp = dec ? 2'b11 : (((nbeats - 1) != int'(len)) ? 2'b10 : 2'b00);
    b_q.push_back(be);

    io_awaddr = addr; io_awid = id; io_awlen = len; io_awsize = 3'd3; io_awburst = burst;
    io_awvalid = 1'b1;
    t = 0;
    while (!io_awready && t < 50) begin tick(); t++; end
    check_value("awready", io_awready, 1'b1);
    tick();
    io_awvalid = 1'b0;

    for (int i = 0; i < nbeats; i++) begin
      io_wvalid = 1'b1; io_wdata = wr_data[i]; io_wstrb = strb; io_wlast = (i == nbeats - 1);
      t = 0;
      while (!io_wready && t < 50) begin tick(); t++; end
      check_value("wready", io_wready, 1'b1);
      tick();
    end
    io_wvalid = 1'b0; io_wlast = 1'b0;

    io_bready = 1'b1;
    t = 0;
    while (!io_bvalid && t < 50) begin tick(); t++; end
    check_value("bvalid", io_bvalid, 1'b1);
    be = b_q.pop_front();
    check_value("bresp", io_bresp, be.resp);
    check_value("bid", io_bid, be.id);
    tick();
    io_bready = 1'b0;
  endtask

  task automatic push_read_exp(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                               input logic [1:0] burst);
    r_exp_t      re;
    logic [31:0] a;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      re.data = (model_inwin(a) && model_mem.exists(model_idx(a))) ? model_mem[model_idx(a)] : 64'h0;
      re.resp = model_inwin(a) ? 2'b00 : 2'b11;
      re.last = (i == int'(len));
      re.id   = id;
      r_q.push_back(re);
      a = model_step(a, burst);
    end
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst);
    int t;
    io_araddr = addr; io_arid = id; io_arlen = len; io_arsize = 3'd3; io_arburst = burst;
    io_arvalid = 1'b1;
    t = 0;
    while (!io_arready && t < 50) begin tick(); t++; end
    check_value("arready", io_arready, 1'b1);
    tick();
    io_arvalid = 1'b0;
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input bit toggle);
    r_exp_t re;
    int     t;
    int     lat;
    bit     ph;
    push_read_exp(addr, id, len, burst);
    send_ar(addr, id, len, burst);
    lat = 1;
    while (!io_rvalid && lat < 20) begin tick(); lat++; end
    check_value("r_latency", lat, EXP_LAT);
    ph = !toggle;
    t  = 0;
    while (r_q.size() > 0 && t < 200) begin
      io_rready = ph;
      if (io_rvalid) begin
        if (ph) begin
          re = r_q.pop_front();
          check_value("rdata", io_rdata, re.data);
          check_value("rresp", io_rresp, re.resp);
          check_value("rlast", io_rlast, re.last);
          check_value("rid", io_rid, re.id);
        end else begin
          check_value("stall_rdata", io_rdata, r_q[0].data);
          check_value("stall_rlast", io_rlast, r_q[0].last);
        end
      end
      tick();
      t++;
      if (toggle) ph = !ph;
    end
    io_rready = 1'b0;
    check_value("r_drained", r_q.size(), 0);
  endtask

  task automatic midburst_reset();
    r_exp_t re;
    int     t;
    push_read_exp(32'h8000_0100, 4'h3, 8'd3, 2'b01);
    send_ar(32'h8000_0100, 4'h3, 8'd3, 2'b01);
    io_rready = 1'b1;
    t = 0;
    while (!io_rvalid && t < 20) begin tick(); t++; end
    for (int i = 0; i < 2; i++) begin
      re = r_q.pop_front();
      check_value("mrst_rdata", io_rdata, re.data);
      tick();
    end
    check_value("mrst_pre_rvalid", io_rvalid, 1'b1);
    reset = 1'b0;
    #1;
    check_value("mrst_rvalid", io_rvalid, 1'b0);
    check_value("mrst_rlast", io_rlast, 1'b0);
    check_value("mrst_rdata0", io_rdata, 64'h0);
    check_value("mrst_arready", io_arready, 1'b0);
    check_value("mrst_awready", io_awready, 1'b0);
    check_value("mrst_wready", io_wready, 1'b0);
    check_value("mrst_bvalid", io_bvalid, 1'b0);
    r_q.delete();
    io_rready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    check_value("post_rst_arready", io_arready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    io_awvalid = 1'b0; io_awaddr = 32'h0; io_awid = 4'h0; io_awlen = 8'd0; io_awsize = 3'd3;
    io_awburst = 2'b01;
    io_wvalid = 1'b0; io_wdata = 64'h0; io_wstrb = 8'h00; io_wlast = 1'b0; io_bready = 1'b0;
    io_arvalid = 1'b0; io_araddr = 32'h0; io_arid = 4'h0; io_arlen = 8'd0; io_arsize = 3'd3;
    io_arburst = 2'b01; io_rready = 1'b0;
    tick(); tick(); tick();
    check_value("rst_arready", io_arready, 1'b0);
    check_value("rst_awready", io_awready, 1'b0);
    check_value("rst_wready", io_wready, 1'b0);
    check_value("rst_bvalid", io_bvalid, 1'b0);
    check_value("rst_rvalid", io_rvalid, 1'b0);
    check_value("rst_bresp", io_bresp, 2'b00);
    check_value("rst_rresp", io_rresp, 2'b00);
    check_value("rst_rdata", io_rdata, 64'h0);
    check_value("rst_rlast", io_rlast, 1'b0);
    check_value("rst_ids", {io_rid, io_bid}, 8'h00);
    reset = 1'b1;
    tick(); tick();

    // single beat write then read
    wr_data[0] = 64'h1122_3344_5566_7788;
    write_burst(32'h8000_0010, 4'h1, 8'd0, 2'b01, 1, 8'hFF);
    read_burst(32'h8000_0010, 4'h2, 8'd0, 2'b01, 1'b0);

    // INCR burst, read back with rready toggling
    for (int i = 0; i < 4; i++) wr_data[i] = 64'(i);
    write_burst(32'h8000_0100, 4'h3, 8'd3, 2'b01, 4, 8'hFF);
    read_burst(32'h8000_0100, 4'h4, 8'd3, 2'b01, 1'b1);

    // strobe merge
    wr_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    write_burst(32'h8000_0200, 4'h1, 8'd0, 2'b01, 1, 8'hFF);
    wr_data[0] = 64'h0;
    write_burst(32'h8000_0200, 4'h1, 8'd0, 2'b01, 1, 8'h0F);
    read_burst(32'h8000_0200, 4'h1, 8'd0, 2'b01, 1'b0);

    // out of window: write must not alias onto word 0
    wr_data[0] = 64'hA5A5_A5A5_5A5A_5A5A;
    write_burst(32'h8000_0000, 4'h2, 8'd0, 2'b01, 1, 8'hFF);
    wr_data[0] = 64'h0123_4567_89AB_CDEF;
    write_burst(32'h9000_0000, 4'h2, 8'd0, 2'b01, 1, 8'hFF);
    read_burst(32'h8000_0000, 4'h2, 8'd0, 2'b01, 1'b0);
    read_burst(32'h7FFF_FFF8, 4'h2, 8'd0, 2'b01, 1'b0);

    // early wlast and ID propagation
    wr_data[0] = 64'hDEAD_BEEF_0000_0001;
    wr_data[1] = 64'hDEAD_BEEF_0000_0002;
    write_burst(32'h8000_0300, 4'hA, 8'd3, 2'b01, 2, 8'hFF);
    read_burst(32'h8000_0300, 4'h5, 8'd1, 2'b01, 1'b0);

    // FIXED burst: both beats land on one word
    wr_data[0] = 64'h1111_1111_1111_1111;
    wr_data[1] = 64'h2222_2222_2222_2222;
    write_burst(32'h8000_0400, 4'h6, 8'd1, 2'b00, 2, 8'hFF);
    read_burst(32'h8000_0400, 4'h7, 8'd1, 2'b00, 1'b0);

    // reset in the middle of a read burst, then confirm the array survived
    midburst_reset();
    read_burst(32'h8000_0100, 4'h8, 8'd3, 2'b01, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
